up_down_counter: RTL and testbench
==================================

# up_down_counter

Parametrised up/down event counter; the next generation of the 3-bit count-up counter in the COUNT unit. Adds configurable width and terminal value, down counting, synchronous load, wrap or saturate modes, optional rising-edge detection on the count strobes, and sticky overflow/underflow flags. It sits in the COUNT unit and feeds ALU status/control logic, which consumes `count` and the terminal/flag outputs.

## Interface

- `WIDTH`, default 3: counter width in bits; legal range is 1..16.
- `MAX_VAL`, default 2**WIDTH-1: terminal (highest) count value; legal range is 1..2**WIDTH-1.
- `EDGE_DET`, default 1: 1 means count on rising edges of the strobes; 0 means count on every cycle a strobe is high.
- `clk`, input, 1 bit: clock; all logic is on the rising edge.
- `resetn`, input, 1 bit: asynchronous active-low reset.
- `count_up`, input, 1 bit: increment strobe, synchronous to `clk`.
- `count_down`, input, 1 bit: decrement strobe, synchronous to `clk`.
- `load`, input, 1 bit: synchronous load request.
- `load_val`, input, WIDTH bits: value to load.
- `sat_mode`, input, 1 bit: 0 selects wrap, 1 selects saturate.
- `clr_flags`, input, 1 bit: clears `ovf` and `unf`.
- `count`, output, WIDTH bits: registered count.
- `tc_max`, output, 1 bit: high when `count == MAX_VAL`.
- `tc_min`, output, 1 bit: high when `count == 0`.
- `ovf`, output, 1 bit: sticky overflow flag.
- `unf`, output, 1 bit: sticky underflow flag.

## Operation

- **Event detection, EDGE_DET=1:** registers `up_q`/`down_q` hold the previous strobe values.
  - `up_ev = count_up & ~up_q`
  - `dn_ev = count_down & ~down_q`
  - A strobe held high produces exactly one event.
- **Event detection, EDGE_DET=0:** `up_ev = count_up`, `dn_ev = count_down`.
- **Priority each cycle, highest first:**
  1. `load`: `count <= min(load_val, MAX_VAL)`. Pending events are discarded and flags are unchanged. Edge registers still update.
  2. `up_ev & dn_ev`: they cancel; count holds and no flag is set.
  3. `up_ev`:
     - if `count < MAX_VAL`, `count+1`;
     - otherwise, with `sat_mode=0`, `count <= 0` and `ovf` sets;
     - otherwise, with `sat_mode=1`, count holds at `MAX_VAL` and `ovf` sets.
  4. `dn_ev`:
     - if `count > 0`, `count-1`;
     - otherwise, with `sat_mode=0`, `count <= MAX_VAL` and `unf` sets;
     - otherwise, with `sat_mode=1`, count holds at 0 and `unf` sets.
  5. Otherwise count holds.
- **Arithmetic:** wrap is against `MAX_VAL`, not against 2**WIDTH. `count` never exceeds `MAX_VAL`.
- **Flags:** `ovf`/`unf` are sticky until `clr_flags`. If `clr_flags` and a new set condition occur in the same cycle, the set wins.
- **Terminal outputs:** `tc_max`/`tc_min` decode the registered `count` combinationally, so they are glitch-free relative to `count`.
- **Mode change:** `sat_mode` may change at any cycle and takes effect at the next event. No state depends on past mode.

## Timing

- **Reset** (`resetn` low, asynchronous, immediate):
  - `count=0`, `ovf=0`, `unf=0`, `up_q=0`, `down_q=0`.
  - Hence `tc_min=1`; `tc_max=0` (since `MAX_VAL>=1`).
- **Reset release:** the first clock edge after `resetn` rises may count. A strobe that is already high at release counts as a rising edge when EDGE_DET=1, because `up_q=0`.
- **Latency:** a strobe, `load` or `clr_flags` sampled high at edge N updates `count` and the flags at edge N, visible after N. This is one-cycle registered latency from the input change.
- **Edge detection, EDGE_DET=1:** a strobe must be low for at least one sampled edge between events. Back-to-back events need a 1-0-1 pattern, so the maximum rate is one event per 2 cycles per strobe.
- **Level counting, EDGE_DET=0:** the maximum rate is one event per cycle.
- **Reset mid-operation:** asynchronous assertion overrides everything in the same cycle. No partial update survives.

## Test plan

Scenarios use `WIDTH=3`, `MAX_VAL=5`, `EDGE_DET=1` unless stated.

1. **Reset:** assert `resetn=0` mid-count at `count=3` → immediately `count=0`, `tc_min=1`, `ovf=unf=0`. Hold `count_up=1` through release → exactly one increment to 1.
2. **Wrap up:** with `sat_mode=0`, issue 6 up pulses (1-0 pattern) → count 1,2,3,4,5,0; `tc_max=1` at 5; `ovf=1` after the 6th pulse and stays 1 until `clr_flags`.
3. **Saturate down:** with `sat_mode=1`, `count=1`, issue 3 down pulses → 0,0,0; `unf=1`; `tc_min=1`. `clr_flags` concurrent with another down pulse → `unf` stays 1.
4. **Load and priority:**
   - `load=1`, `load_val=7` → `count=5` (clamped).
   - `load=1`, `load_val=2` with `count_up` edge in the same cycle → `count=2`, no increment.
   - Simultaneous up and down edges → count unchanged, no flag.
5. **Level mode:** with `EDGE_DET=0`, `WIDTH=4`, `MAX_VAL=9`, `sat_mode=0`, hold `count_up=1` for 12 cycles → 1..9,0,1,2; `ovf` sets at the 10th edge.
6. **Held strobe:** with `EDGE_DET=1`, `count_up` held high for 8 cycles → exactly one increment.

Source files
------------

// File: rtl/up_down_counter_if.sv
// Strobe/control and status bundle for up_down_counter.
// The master drives the strobes and controls; the slave (the counter) drives the status.
interface up_down_counter_if #(parameter int WIDTH = 3);
   logic             count_up;
   logic             count_down;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             sat_mode;
   logic             clr_flags;
   logic [WIDTH-1:0] count;
   logic             tc_max;
   logic             tc_min;
   logic             ovf;
   logic             unf;

   modport master (
      output count_up, count_down, load, load_val, sat_mode, clr_flags,
      input  count, tc_max, tc_min, ovf, unf
   );

   modport slave (
      input  count_up, count_down, load, load_val, sat_mode, clr_flags,
      output count, tc_max, tc_min, ovf, unf
   );
endinterface

// File: rtl/up_down_counter.sv
// Up/down event counter with a terminal value, a load input, wrap or saturate behaviour,
// optional edge-detected strobes, and sticky overflow/underflow flags.
module up_down_counter #(
   parameter int WIDTH    = 3,
   parameter int MAX_VAL  = (1 << WIDTH) - 1,
   parameter int EDGE_DET = 1
) (
   input logic              clk,
   input logic              resetn,
   up_down_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] cnt;
   logic             ovf_r, unf_r;
   logic             up_ev, dn_ev;

   // Previous strobe values reset to 0, so a strobe already high at reset release counts once
   if (EDGE_DET != 0) begin : g_edge
      logic up_q, down_q;
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
         end else begin
            up_q   <= bus.count_up;
            down_q <= bus.count_down;
         end
      end
      assign up_ev = bus.count_up & ~up_q;
      assign dn_ev = bus.count_down & ~down_q;
   end else begin : g_level
      assign up_ev = bus.count_up;
      assign dn_ev = bus.count_down;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         // Clear first; a set later in this block wins.
         if (bus.clr_flags) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
         end
         if (bus.load) begin
            cnt <= (bus.load_val > MAXV) ? MAXV : bus.load_val;
         end else if (up_ev && !dn_ev) begin
            if (cnt < MAXV) begin
               cnt <= cnt + ONE;
            end else begin
               ovf_r <= 1'b1;
               if (!bus.sat_mode) cnt <= '0;
            end
         end else if (dn_ev && !up_ev) begin
            if (cnt != '0) begin
               cnt <= cnt - ONE;
            end else begin
               unf_r <= 1'b1;
               if (!bus.sat_mode) cnt <= MAXV;
            end
         end
      end
   end

   assign bus.count  = cnt;
   assign bus.tc_max = (cnt == MAXV);
   assign bus.tc_min = (cnt == '0);
   assign bus.ovf    = ovf_r;
   assign bus.unf    = unf_r;
endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench: edge-mode counter (3 bits, terminal 5) and level-mode counter (4 bits, terminal 9).
module tb_up_down_counter;
   logic clk;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   up_down_counter_if #(.WIDTH(3)) a_if ();
   up_down_counter_if #(.WIDTH(4)) b_if ();

   up_down_counter #(.WIDTH(3), .MAX_VAL(5), .EDGE_DET(1)) dut_a (
      .clk(clk), .resetn(resetn), .bus(a_if.slave)
   );
   up_down_counter #(.WIDTH(4), .MAX_VAL(9), .EDGE_DET(0)) dut_b (
      .clk(clk), .resetn(resetn), .bus(b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 1-0 pulse on count_up; count updates at the first edge.
   task automatic up_pulse();
      a_if.count_up = 1'b1;
      tick();
      a_if.count_up = 1'b0;
      tick();
   endtask

   task automatic dn_pulse();
      a_if.count_down = 1'b1;
      tick();
      a_if.count_down = 1'b0;
      tick();
   endtask

   task automatic load_a(input logic [2:0] v);
      a_if.load = 1'b1;
      a_if.load_val = v;
      tick();
      a_if.load = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      a_if.count_up = 0; a_if.count_down = 0; a_if.load = 0; a_if.load_val = '0;
      a_if.sat_mode = 0; a_if.clr_flags = 0;
      b_if.count_up = 0; b_if.count_down = 0; b_if.load = 0; b_if.load_val = '0;
      b_if.sat_mode = 0; b_if.clr_flags = 0;
      tick(); tick();
      resetn = 1'b1;
      tick();
      chk("rst_count", a_if.count, 0);
      chk("rst_tc_min", a_if.tc_min, 1);
      chk("rst_tc_max", a_if.tc_max, 0);
      chk("rst_ovf", a_if.ovf, 0);
      chk("rst_unf", a_if.unf, 0);

      // Reset mid-count at 3, strobe held through release
      up_pulse(); up_pulse(); up_pulse();
      chk("pre_rst_count", a_if.count, 3);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_count", a_if.count, 0);
      chk("async_rst_tc_min", a_if.tc_min, 1);
      a_if.count_up = 1'b1;
      tick();
      resetn = 1'b1;
      tick();
      chk("release_one_inc", a_if.count, 1);
      tick(); tick(); tick();
      chk("release_held", a_if.count, 1);
      a_if.count_up = 1'b0;
      tick();

      // Wrap up from 0 with six pulses
      load_a(3'd0);
      tick();
      chk("load0", a_if.count, 0);
      for (int k = 1; k <= 6; k++) begin
         up_pulse();
         chk("wrap_count", a_if.count, k % 6);
         chk("wrap_tc_max", a_if.tc_max, (k == 5) ? 1 : 0);
         chk("wrap_ovf", a_if.ovf, (k == 6) ? 1 : 0);
      end
      up_pulse();
      chk("ovf_sticky", a_if.ovf, 1);
      chk("ovf_sticky_count", a_if.count, 1);
      a_if.clr_flags = 1'b1;
      tick();
      a_if.clr_flags = 1'b0;
      chk("ovf_clr", a_if.ovf, 0);

      // Saturate down from 1
      a_if.sat_mode = 1'b1;
      load_a(3'd1);
      tick();
      dn_pulse();
      chk("sat_dn1", a_if.count, 0);
      chk("sat_dn1_unf", a_if.unf, 0);
      dn_pulse();
      chk("sat_dn2", a_if.count, 0);
      chk("sat_dn2_unf", a_if.unf, 1);
      dn_pulse();
      chk("sat_dn3", a_if.count, 0);
      chk("sat_tc_min", a_if.tc_min, 1);
      a_if.clr_flags = 1'b1;
      a_if.count_down = 1'b1;
      tick();
      a_if.clr_flags = 1'b0;
      a_if.count_down = 1'b0;
      chk("set_beats_clr", a_if.unf, 1);
      tick();
      a_if.clr_flags = 1'b1;
      tick();
      a_if.clr_flags = 1'b0;
      chk("unf_clr", a_if.unf, 0);

      // Load clamps; saturate up at terminal
      load_a(3'd7);
      chk("load_clamp", a_if.count, 5);
      chk("load_tc_max", a_if.tc_max, 1);
      up_pulse();
      chk("sat_up_count", a_if.count, 5);
      chk("sat_up_ovf", a_if.ovf, 1);
      a_if.clr_flags = 1'b1;
      tick();
      a_if.clr_flags = 1'b0;

      // Load wins over a same-cycle up edge
      a_if.load = 1'b1;
      a_if.load_val = 3'd2;
      a_if.count_up = 1'b1;
      tick();
      a_if.load = 1'b0;
      a_if.count_up = 1'b0;
      chk("load_prio", a_if.count, 2);
      tick();
      chk("load_prio_hold", a_if.count, 2);

      // Simultaneous edges cancel
      a_if.count_up = 1'b1;
      a_if.count_down = 1'b1;
      tick();
      a_if.count_up = 1'b0;
      a_if.count_down = 1'b0;
      chk("cancel_count", a_if.count, 2);
      chk("cancel_ovf", a_if.ovf, 0);
      chk("cancel_unf", a_if.unf, 0);
      tick();

      // Wrap down from 0
      a_if.sat_mode = 1'b0;
      load_a(3'd0);
      tick();
      dn_pulse();
      chk("wrap_dn_count", a_if.count, 5);
      chk("wrap_dn_unf", a_if.unf, 1);

      // Held strobe gives exactly one increment
      load_a(3'd2);
      a_if.count_up = 1'b1;
      tick();
      chk("held_first", a_if.count, 3);
      for (int k = 0; k < 7; k++) tick();
      chk("held_eight", a_if.count, 3);
      a_if.count_up = 1'b0;
      tick();

      // Level mode: count every cycle, wrap at 9
      chk("lvl_start", b_if.count, 0);
      b_if.count_up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("lvl_count", b_if.count, k % 10);
         chk("lvl_ovf", b_if.ovf, (k >= 10) ? 1 : 0);
      end
      b_if.count_up = 1'b0;
      tick();
      chk("lvl_hold", b_if.count, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
